// File: rtl/btn_seq_pkg.sv
// Shared types and constants for the button-press sequencer.
package btn_seq_pkg;

  localparam int unsigned HOLD_MIN = 6;
  localparam int unsigned GAP_MIN  = 6;
  localparam int unsigned VAL_W    = 4;
  localparam int unsigned PHASE_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_HI,
    S_CLR_LO,
    S_STEP_HI,
    S_STEP_LO,
    S_DONE
  } state_t;

  // Entry-register step as the game performs it: saturating, never wrapping.
  function automatic logic [VAL_W-1:0] step_value(input logic [VAL_W-1:0] v,
                                                  input logic up);
    if (up) return (v == '1) ? v : v + VAL_W'(1);
    else    return (v == '0) ? v : v - VAL_W'(1);
  endfunction

endpackage

// File: rtl/btn_press_timer.sv
// Loadable down-counter shared by the hold and gap phases; expired when zero.
module btn_press_timer
  import btn_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  output logic               expired
);

  logic [PHASE_W-1:0] count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               count <= '0;
    else if (load)         count <= load_val;
    else if (count != '0)  count <= count - PHASE_W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/btn_press_sequencer.sv
// Emits timed clear/up/down presses that drive the game's entry register to
// a target value. Optional feature macro: BTNSEQ_RELATIVE_EN (skip the clear
// press and step relative to the known entry value).
module btn_press_sequencer
  import btn_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] target,
  output logic             busy,
  output logic             done,
  output logic             btn_clr,
  output logic             btn_up,
  output logic             btn_dn,
  output logic [VAL_W-1:0] value
);

  if (HOLD_CYCLES < HOLD_MIN || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 6..255");
  end
  if (GAP_CYCLES < GAP_MIN || GAP_CYCLES > 255) begin : g_bad_gap
    $error("GAP_CYCLES must be in 6..255");
  end

  localparam logic [PHASE_W-1:0] HOLD_LOAD = PHASE_W'(HOLD_CYCLES - 1);
  localparam logic [PHASE_W-1:0] GAP_LOAD  = PHASE_W'(GAP_CYCLES - 1);

  state_t             state, state_next;
  logic [VAL_W-1:0]   tgt, tgt_next, value_next;
  logic               phase_exp, load;
  logic [PHASE_W-1:0] load_val;
  logic               busy_next, done_next, clr_next, up_next, dn_next;
`ifdef BTNSEQ_RELATIVE_EN
  logic               known, known_next;
`endif

  btn_press_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expired  (phase_exp)
  );

  // Next state, latched target/value, and the registered-output images.
  // Outputs are decoded from the next state so they appear in the same
  // cycle the state register enters that state.
  always_comb begin
    state_next = state;
    tgt_next   = tgt;
    value_next = value;
`ifdef BTNSEQ_RELATIVE_EN
    known_next = known;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          tgt_next   = target;
          state_next = S_CLR_HI;
`ifdef BTNSEQ_RELATIVE_EN
          if (known) state_next = (target == value) ? S_DONE : S_STEP_HI;
`endif
        end
      end
      S_CLR_HI: begin
        if (phase_exp) begin
          state_next = S_CLR_LO;
          value_next = '0;
`ifdef BTNSEQ_RELATIVE_EN
          known_next = 1'b1;
`endif
        end
      end
      S_CLR_LO, S_STEP_LO: begin
        if (phase_exp) state_next = (value != tgt) ? S_STEP_HI : S_DONE;
      end
      S_STEP_HI: begin
        if (phase_exp) begin
          state_next = S_STEP_LO;
          value_next = step_value(value, tgt > value);
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    load = (state_next != state);
    case (state_next)
      S_CLR_HI, S_STEP_HI: load_val = HOLD_LOAD;
      S_CLR_LO, S_STEP_LO: load_val = GAP_LOAD;
      default:             load_val = '0;
    endcase

    busy_next = (state_next != S_IDLE) && (state_next != S_DONE);
    done_next = (state_next == S_DONE);
    clr_next  = (state_next == S_CLR_HI);
    up_next   = (state_next == S_STEP_HI) && (tgt_next > value_next);
    dn_next   = (state_next == S_STEP_HI) && (tgt_next < value_next);
  end

  // State and registered outputs; reset drops every button line at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      tgt     <= '0;
      value   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      btn_clr <= 1'b0;
      btn_up  <= 1'b0;
      btn_dn  <= 1'b0;
    end else begin
      state   <= state_next;
      tgt     <= tgt_next;
      value   <= value_next;
      busy    <= busy_next;
      done    <= done_next;
      btn_clr <= clr_next;
      btn_up  <= up_next;
      btn_dn  <= dn_next;
    end
  end

`ifdef BTNSEQ_RELATIVE_EN
  // Entry value becomes known after any completed clear press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) known <= 1'b0;
    else     known <= known_next;
  end
`endif

endmodule

// File: tb/tb_btn_press_sequencer.sv
// Scoreboard bench: stimulus pushes predicted runs, a monitor decodes the
// button lines into presses, models the game's entry register and checks.
module tb_btn_press_sequencer;

  localparam int HOLD = 8;
  localparam int GAP  = 8;
  localparam int DEB  = 7;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] target;
  logic       busy, done, btn_clr, btn_up, btn_dn;
  logic [3:0] value;

  always #5 clk = ~clk;

  btn_press_sequencer #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .busy(busy), .done(done), .btn_clr(btn_clr), .btn_up(btn_up),
    .btn_dn(btn_dn), .value(value)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int tgt; int start_cyc; int lat; int n_clr; int n_up; int n_dn;
  } exp_t;
  exp_t exp_q[$];

  int m_val = 0;
`ifdef BTNSEQ_RELATIVE_EN
  bit m_known = 1'b0;
`endif

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: what a run to t must look like, from the entry value it starts at.
  task automatic predict(input int t, input int sc, output exp_t e);
    e.tgt = t; e.start_cyc = sc; e.n_clr = 0; e.n_up = 0; e.n_dn = 0;
`ifdef BTNSEQ_RELATIVE_EN
    if (m_known) begin
      if (t > m_val) e.n_up = t - m_val; else e.n_dn = m_val - t;
      e.lat = (e.n_up + e.n_dn) * (HOLD + GAP) + 1;
    end else
`endif
    begin
      e.n_clr = 1; e.n_up = t;
      e.lat = (1 + t) * (HOLD + GAP) + 1;
`ifdef BTNSEQ_RELATIVE_EN
      m_known = 1'b1;
`endif
    end
    m_val = t;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_val = 0;
`ifdef BTNSEQ_RELATIVE_EN
    m_known = 1'b0;
`endif
  endtask

  // ---------------- monitor ----------------
  int game_entry = 0;
  int hold_cnt = 0, gap_cnt = 0, n_press = 0;
  int r_clr = 0, r_up = 0, r_dn = 0;
  bit [2:0] prev = '0, cur;

  task automatic run_clear();
    hold_cnt = 0; gap_cnt = 0; n_press = 0; r_clr = 0; r_up = 0; r_dn = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        run_clear();
        prev = '0;
        continue;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency", cyc - e.start_cyc, e.lat);
          check("value", int'(value), e.tgt);
          check("game_entry", game_entry, e.tgt);
          check("clr_presses", r_clr, e.n_clr);
          check("up_presses", r_up, e.n_up);
          check("dn_presses", r_dn, e.n_dn);
          check("busy_at_done", int'(busy), 0);
          if (n_press > 0) check("final_gap", gap_cnt, GAP);
        end
        run_clear();
      end
      cur = {btn_clr, btn_up, btn_dn};
      if (cur != '0) begin
        check("one_line_high", $countones(cur), 1);
        if (prev == '0) begin
          if (n_press > 0) check("gap_len", gap_cnt, GAP);
          check("busy_in_press", int'(busy), 1);
          hold_cnt = 1;
        end else if (cur == prev) begin
          hold_cnt++;
        end else begin
          check("line_switch_without_gap", 1, 0);
          hold_cnt = 1;
        end
      end else if (prev != '0) begin
        check("hold_len", hold_cnt, HOLD);
        if (hold_cnt >= DEB) begin
          if (prev[2]) game_entry = 0;
          else if (prev[1]) game_entry = (game_entry == 15) ? 15 : game_entry + 1;
          else game_entry = (game_entry == 0) ? 0 : game_entry - 1;
        end
        if (prev[2]) r_clr++;
        if (prev[1]) r_up++;
        if (prev[0]) r_dn++;
        n_press++;
        gap_cnt = 1;
      end else if (n_press > 0) begin
        gap_cnt++;
      end
      prev = cur;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int t);
    exp_t e;
    @(posedge clk); #1;
    target = 4'(t);
    start  = 1'b1;
    predict(t, cyc, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic recover();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(input int t, input bit disturb);
    bit seen;
    seen = 1'b0;
    issue(t);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      if (disturb && k == 40) begin start = 1'b1; target = 4'd3; end
      if (disturb && k == 41) start = 1'b0;
    end
    start = 1'b0;
    check("done_within_bound", int'(seen), 1);
    if (!seen) recover();
  endtask

  task automatic reset_mid_run(input int t);
    int  rises;
    bit  hit;
    logic [1:0] pv;
    rises = 0; hit = 1'b0; pv = '0;
    issue(t);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if ({btn_up, btn_dn} != 2'b00 && pv == 2'b00) rises++;
      pv = {btn_up, btn_dn};
      if (rises == 3) begin hit = 1'b1; break; end
    end
    check("third_step_press_seen", int'(hit), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_btn_clr", int'(btn_clr), 0);
    check("rst_btn_up", int'(btn_up), 0);
    check("rst_btn_dn", int'(btn_dn), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_value", int'(value), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_btn_clr", int'(btn_clr), 0);
    check("reset_btn_up", int'(btn_up), 0);
    check("reset_btn_dn", int'(btn_dn), 0);
    check("reset_value", int'(value), 0);
    rst = 1'b0;

    run(0, 1'b0);
    run(5, 1'b0);
    run(15, 1'b1);
    reset_mid_run(9);
    run(2, 1'b0);
    run(7, 1'b0);
    run(4, 1'b0);
    run(4, 1'b0);
    for (int i = 0; i < 20; i++) run(int'($urandom_range(0, 15)), 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
